// File: rtl/inv_permutation_iter.sv
// Iterative inverse of the 320-bit Ascon-style permutation p^n with valid/ready handshakes.
// Define INV_PERM_UNROLL2_EN to apply two inverse rounds per clock edge.
module inv_permutation_iter #(
    parameter int MAX_ROUNDS = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [319:0] sin,
    input  logic [3:0]   rounds_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [319:0] sout,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] MAX_R = MAX_ROUNDS[3:0];

    localparam logic [4:0] INV_SBOX [32] = '{
        5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
        5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
        5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
        5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
    };

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    // L = 1 + e over GF(2)[t]/(t^64+1) with e^64 = 0, so L^-1 = prod_{i<6} (1 + e^(2^i)),
    // and each factor is again a three-term rotate-XOR with doubled rotation amounts.
    function automatic logic [63:0] lin_inv(input logic [63:0] x, input int word);
        logic [63:0] y;
        int a, b;
        a = 7;
        b = 41;
        case (word)
            0: begin a = 19; b = 28; end
            1: begin a = 61; b = 39; end
            2: begin a = 1;  b = 6;  end
            3: begin a = 10; b = 17; end
            default: ;
        endcase
        y = x;
        for (int i = 0; i < 6; i++)
            y = y ^ rotr64(y, (a << i) % 64) ^ rotr64(y, (b << i) % 64);
        return y;
    endfunction

    function automatic logic [319:0] inv_round(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] w [5];
        logic [4:0]  v;
        logic [4:0]  y;
        for (int i = 0; i < 5; i++)
            w[i] = lin_inv(s[319-64*i -: 64], i);
        for (int j = 0; j < 64; j++) begin
            v = {w[0][j], w[1][j], w[2][j], w[3][j], w[4][j]};
            y = INV_SBOX[v];
            w[0][j] = y[4];
            w[1][j] = y[3];
            w[2][j] = y[2];
            w[3][j] = y[1];
            w[4][j] = y[0];
        end
        w[2][7:0] = w[2][7:0] ^ {4'hF - r, r};
        return {w[0], w[1], w[2], w[3], w[4]};
    endfunction

    state_t         state_q, state_d;
    logic [319:0]   st_q, st_d;
    logic [3:0]     r_q, r_d;
    logic [3:0]     lo_q, lo_d;
    logic [3:0]     n_clamp;
    logic [319:0]   rnd1;

    assign rnd1 = inv_round(st_q, r_q);
`ifdef INV_PERM_UNROLL2_EN
    logic [319:0]   rnd2;
    assign rnd2 = inv_round(rnd1, r_q - 4'd1);
`endif

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        r_d     = r_q;
        lo_d    = lo_q;
        n_clamp = (rounds_in > MAX_R) ? MAX_R : rounds_in;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    st_d    = sin;
                    lo_d    = MAX_R - n_clamp;
                    r_d     = MAX_R - 4'd1;
                    state_d = (n_clamp == 4'd0) ? DONE : RUN;
                end
            end
            RUN: begin
`ifdef INV_PERM_UNROLL2_EN
                if (r_q == lo_q) begin
                    st_d    = rnd1;
                    state_d = DONE;
                end else begin
                    st_d = rnd2;
                    if (r_q - 4'd1 == lo_q) state_d = DONE;
                    else                    r_d     = r_q - 4'd2;
                end
`else
                st_d = rnd1;
                if (r_q == lo_q) state_d = DONE;
                else             r_d     = r_q - 4'd1;
`endif
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: the 320-bit state is reset on purpose, sout must read zero after an abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= '0;
            r_q  <= '0;
            lo_q <= '0;
        end else begin
            st_q <= st_d;
            r_q  <= r_d;
            lo_q <= lo_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sout      = st_q;

endmodule
